// File: rtl/nano_mem_line_responder.sv
// Line-to-word bridge: accepts 8-word (32-byte) line reads/writes and
// services them as eight in-order 32-bit beats on a word SRAM port.
module nano_mem_line_responder (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mm_rden,
    input  logic             i_mm_wren,
    input  logic [31:0]      i_mm_addr,
    input  logic [7:0][31:0] i_mm_wdata,
    output logic [7:0][31:0] o_mm_rdata,
    output logic             o_mm_rvalid,
    output logic             o_mm_gnt,
    output logic             o_sram_rden,
    output logic             o_sram_wren,
    output logic [31:0]      o_sram_addr,
    output logic [31:0]      o_sram_wdata,
    output logic [3:0]       o_sram_wstrb,
    input  logic             i_sram_gnt,
    input  logic [31:0]      i_sram_rdata,
    input  logic             i_sram_rvalid,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state;
    logic [26:0]      line_q;
    logic [7:0][31:0] wbuf_q;
    logic [6:0][31:0] rbuf_q;
    logic [3:0]       issue_cnt;
    logic [3:0]       rx_cnt;
    logic             beat_active;
    logic             rx_take;
    logic             unused_addr_bits;

    // Handshakes: a master request is held until o_mm_gnt; an SRAM beat
    // transfers on any cycle where its rden/wren and i_sram_gnt are both 1.
    assign o_mm_gnt     = (state == IDLE) && (i_mm_rden || i_mm_wren);
    assign o_sram_wren  = (state == WR);
    assign o_sram_rden  = (state == RD) && !issue_cnt[3];
    assign beat_active  = o_sram_wren || o_sram_rden;
    assign o_sram_addr  = beat_active ? {line_q, issue_cnt[2:0], 2'b00} : 32'h0;
    assign o_sram_wdata = o_sram_wren ? wbuf_q[issue_cnt[2:0]] : 32'h0;
    assign o_sram_wstrb = o_sram_wren ? 4'hF : 4'h0;
    assign dbg_state    = state;
    assign rx_take      = (state == RD) && i_sram_rvalid && !rx_cnt[3];

    assign unused_addr_bits = ^i_mm_addr[4:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            line_q      <= '0;
            wbuf_q      <= '0;
            rbuf_q      <= '0;
            issue_cnt   <= '0;
            rx_cnt      <= '0;
            o_mm_rdata  <= '0;
            o_mm_rvalid <= 1'b0;
        end else begin
            o_mm_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (o_mm_gnt) begin
                        line_q    <= i_mm_addr[31:5];
                        issue_cnt <= '0;
                        rx_cnt    <= '0;
                        if (i_mm_wren) begin
                            wbuf_q <= i_mm_wdata;
                            state  <= WR;
                        end else begin
                            state  <= RD;
                        end
                    end
                end
                WR: begin
                    if (i_sram_gnt) begin
                        issue_cnt <= issue_cnt + 4'd1;
                        if (issue_cnt == 4'd7) begin
                            state       <= RESP;
                            o_mm_rvalid <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (o_sram_rden && i_sram_gnt)
                        issue_cnt <= issue_cnt + 4'd1;
                    if (rx_take) begin
                        rx_cnt <= rx_cnt + 4'd1;
                        // The last word goes straight to the output so the
                        // published line only ever changes as a whole.
                        if (rx_cnt == 4'd7) begin
                            o_mm_rdata  <= {i_sram_rdata, rbuf_q};
                            state       <= RESP;
                            o_mm_rvalid <= 1'b1;
                        end else begin
                            rbuf_q[rx_cnt[2:0]] <= i_sram_rdata;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/nano_mem_line_responder.md
NANO_MEM_LINE_RESPONDER -- requirements
Module: nano_mem_line_responder

Interface
REQ-001 SHALL have ports: i_clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: i_rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: i_mm_rden  in  1  line-read request, held until granted.
REQ-004 SHALL have ports: i_mm_wren  in  1  line-write request, held until granted.
REQ-005 SHALL have ports: i_mm_addr  in  32  line address; bits [4:0] ignored.
REQ-006 SHALL have ports: i_mm_wdata  in  8x32  write line; word k at slot k.
REQ-007 SHALL have ports: o_mm_rdata  out  8x32  read line; word k at slot k.
REQ-008 SHALL have ports: o_mm_rvalid  out  1  one-cycle completion pulse, read or write.
REQ-009 SHALL have ports: o_mm_gnt  out  1  request accepted this cycle.
REQ-010 SHALL have ports: o_sram_rden / o_sram_wren  out  1 each  word-port beat request.
REQ-011 SHALL have ports: o_sram_addr  out  32  word byte address; o_sram_wdata  out  32; o_sram_wstrb  out  4.
REQ-012 SHALL have ports: i_sram_gnt  in  1  beat accepted; i_sram_rdata  in  32; i_sram_rvalid  in  1  in-order read return.

Function
REQ-013 SHALL implement FSM states IDLE, WR, RD, RESP.
REQ-014 o_mm_gnt SHALL be combinational: 1 iff state==IDLE and (i_mm_rden or i_mm_wren).
REQ-015 On grant SHALL latch {i_mm_addr[31:5], 5'b0} and, for writes, i_mm_wdata; next state WR if i_mm_wren else RD.
REQ-016 i_mm_rden and i_mm_wren both high in IDLE: write SHALL win; rden stays pending and is granted on next IDLE cycle.
REQ-017 Beat k (0..7) SHALL use o_sram_addr = {line[31:5], k[2:0], 2'b00}; beats issued strictly in order 0..7.
REQ-018 WR: o_sram_wren=1, o_sram_wstrb=4'hF, o_sram_wdata=latched word[issue_cnt]; issue_cnt (4-bit) increments on i_sram_gnt.
REQ-019 WR SHALL go to RESP on the cycle the 8th beat is granted.
REQ-020 RD: o_sram_rden=1 while issue_cnt<8; issue_cnt increments on i_sram_gnt; request dropped after 8 grants.
REQ-021 RD: each i_sram_rvalid SHALL store i_sram_rdata into slot rx_cnt and increment rx_cnt; issue and return may coincide.
REQ-022 RD SHALL go to RESP on the cycle the 8th return is captured; o_mm_rdata SHALL update only from RD captures.
REQ-023 RESP: o_mm_rvalid=1 for exactly one cycle, then IDLE; no grant in RESP.
REQ-024 o_mm_rdata SHALL hold its value from the last completed read until the next read completes.
REQ-025 i_sram_rvalid outside RD, or beyond 8 returns, SHALL be ignored.
REQ-026 o_sram_rden and o_sram_wren SHALL never both be 1; both 0 in IDLE and RESP.
REQ-027 With i_sram_gnt=1 always and 1-cycle read latency: grant at cycle 0, write rvalid at cycle 9, read rvalid at cycle 10.

Reset
REQ-028 i_rst SHALL force IDLE, issue_cnt=rx_cnt=0, latched line/data=0, o_mm_rdata=0, o_mm_rvalid=0, all o_sram_* = 0.
REQ-029 Reset mid-transfer SHALL abort with no o_mm_rvalid; first cycle after release accepts new requests.

Verification
REQ-030 Write: wren, addr=0x0000_1234, wdata word k=0xA0+k, gnt tied 1 -> beats at 0x1220..0x123C, data 0xA0..0xA7, wstrb F, rvalid at cycle 9.
REQ-031 Read: rden, addr=0x0000_1220, SRAM model returns 0xB0+k after 1 cycle -> o_mm_rdata word k=0xB0+k, rvalid at cycle 10, exactly one pulse.
REQ-032 Backpressure: i_sram_gnt low on alternate cycles, read returns 3 cycles late -> correct ordering, rvalid only after 8th capture.
REQ-033 Simultaneous rden+wren at 0x40 -> write completes first (rvalid), then rden granted next IDLE, second rvalid with read data.
REQ-034 Reset asserted after 4 read beats -> outputs zero, no rvalid; new read after release completes normally with fresh data.
REQ-035 Stray i_sram_rvalid in IDLE/WR with 0xDEAD -> o_mm_rdata unchanged, no rvalid.
